cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
// Arbitrates the common data bus (CDB) between the add/sub and mul/div functional units.
// Each unit pushes completed results (reservation-station tag + value) into its own small FIFO.
// The arbiter pops one result per cycle, round-robin between the two FIFOs, into a registered
// broadcast. Reservation stations and the register file consume the broadcast.
// PARAMETERS
// TAG_W    3  width of reservation-station tag carried with each result
// DATA_W   9  width of result value (matches Bus width)
// DEPTH    2  entries per requester FIFO (power of 2, >=2)
// PORTS
// Clock    in   1       system clock, all state updates on rising edge
// Clear    in   1       synchronous active-high reset
// pushAS   in   1       add/sub unit presents a result this cycle
// tagAS    in   TAG_W   add/sub result tag
// dataAS   in   DATA_W  add/sub result value
// fullAS   out  1       add/sub FIFO holds DEPTH entries; unit must not push
// pushMD   in   1       mul/div unit presents a result this cycle
// tagMD    in   TAG_W   mul/div result tag
// dataMD   in   DATA_W  mul/div result value
// fullMD   out  1       mul/div FIFO holds DEPTH entries
// cdbHold  in   1       consumer busy; no grant this cycle
// cdbValid out  1       broadcast valid, exactly one cycle per result
// cdbSrc   out  1       source of current broadcast: 0 = add/sub, 1 = mul/div
// cdbTag   out  TAG_W   broadcast tag
// cdbData  out  DATA_W  broadcast value
// idle     out  1       both FIFOs empty and cdbValid low
// BEHAVIOUR
// - Reset (Clear=1 at edge): FIFOs emptied, counts=0, fullAS=fullMD=0, cdbValid=0, cdbSrc=0,
//   cdbTag=0, cdbData=0, lastGrant=1 (MD). Add/sub wins the first tie. Clear overrides every
//   push, pop and hold in that cycle. A Clear mid-operation discards all queued results.
// - Push: accepted at an edge iff pushX=1 and fullX=0. Push while full is ignored: no state
//   change, no error flag. fullX is registered (count==DEPTH) and does not anticipate a pop
//   in the same cycle.
// - Grant (evaluated each cycle on registered FIFO state, Clear=0, cdbHold=0):
//   - both non-empty: grant the unit != lastGrant
//   - one non-empty: grant it
//   - none: no grant
// - On grant: pop the head; at the edge load cdbTag/cdbData/cdbSrc from it, set cdbValid=1,
//   lastGrant=granted unit. No grant: cdbValid=0 at the edge, and cdbTag/cdbData/cdbSrc hold
//   their last values.
// - cdbHold=1: no pop, cdbValid=0 next cycle, FIFOs and lastGrant unchanged. Pushes are
//   still accepted.
// - Same-queue push and pop in one cycle: both occur, count unchanged, FIFO order preserved.
// - Latency: a push at edge E into an empty system (no hold) gives cdbValid=1 in the cycle
//   after edge E+1 (2 edges, no bypass).
// - Throughput: 1 result/cycle. With both FIFOs continuously non-empty, grants alternate
//   AS,MD,AS,... Neither unit waits more than one grant.
// - FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits,
//   range 0..DEPTH.
// - idle = (countAS==0)&&(countMD==0)&&!cdbValid, combinational from registers.
// TESTING
// - Reset: hold Clear 2 cycles with pushAS=pushMD=1 -> all outputs 0, idle=1, no entries queued.
// - Single: pushAS tag=3 data=9'h055 once -> two edges later cdbValid=1 for exactly 1 cycle,
//   cdbSrc=0, cdbTag=3, cdbData=9'h055. idle=1 afterwards.
// - Tie/RR: after reset push AS(tag1) and MD(tag5) in the same cycle -> broadcasts AS tag1
//   then MD tag5 on consecutive cycles. Repeat -> order remains AS,MD.
// - Full: cdbHold=1, push AS 3 times (tags 1,2,3) -> fullAS=1 after the 2nd push, 3rd push
//   dropped. Release hold -> only tags 1,2 broadcast, in order.
// - Hold: queue MD tag 4, assert cdbHold 3 cycles -> cdbValid stays 0. Deassert -> tag 4
//   broadcast next edge. lastGrant is not advanced by the hold.
// - Clear mid-stream: both FIFOs full, pulse Clear -> next cycle cdbValid=0, fullAS=fullMD=0,
//   idle=1, and no stale tag is ever broadcast.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two small result FIFOs (add/sub, mul/div) drained
// round-robin, one result per cycle, into a registered broadcast.
module cdb_arbiter #(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 9,
  parameter int DEPTH  = 2
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              pushAS,
  input  logic [TAG_W-1:0]  tagAS,
  input  logic [DATA_W-1:0] dataAS,
  output logic              fullAS,
  input  logic              pushMD,
  input  logic [TAG_W-1:0]  tagMD,
  input  logic [DATA_W-1:0] dataMD,
  output logic              fullMD,
  input  logic              cdbHold,
  output logic              cdbValid,
  output logic              cdbSrc,
  output logic [TAG_W-1:0]  cdbTag,
  output logic [DATA_W-1:0] cdbData,
  output logic              idle
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + DATA_W;

  typedef enum logic {SRC_AS = 1'b0, SRC_MD = 1'b1} src_t;

  // Index 0 = add/sub queue, index 1 = mul/div queue.
  logic [ENT_W-1:0] mem [2][DEPTH];
  logic [PTR_W-1:0] wr_ptr [2];
  logic [PTR_W-1:0] rd_ptr [2];
  logic [CNT_W-1:0] count  [2];

  logic [1:0]       push_req;
  logic [1:0]       push_ok;
  logic [1:0]       pop;
  logic [ENT_W-1:0] wr_data [2];
  logic [ENT_W-1:0] head    [2];
  logic [ENT_W-1:0] sel_head;
  src_t             last_grant;
  src_t             grant_src;
  logic             grant_valid;

  always_comb begin
    push_req   = {pushMD, pushAS};
    wr_data[0] = {tagAS, dataAS};
    wr_data[1] = {tagMD, dataMD};
    for (int unsigned u = 0; u < 2; u++) begin
      push_ok[u] = push_req[u] && (count[u] != CNT_W'(DEPTH));
      head[u]    = mem[u][rd_ptr[u]];
    end
  end

  // Tie goes to the unit that did not win last; lastGrant resets to MD so AS wins first.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_AS;
    if (!cdbHold) begin
      if ((count[0] != '0) && (count[1] != '0)) begin
        grant_valid = 1'b1;
        grant_src   = (last_grant == SRC_AS) ? SRC_MD : SRC_AS;
      end else if (count[0] != '0) begin
        grant_valid = 1'b1;
        grant_src   = SRC_AS;
      end else if (count[1] != '0) begin
        grant_valid = 1'b1;
        grant_src   = SRC_MD;
      end
    end
    pop[0]   = grant_valid && (grant_src == SRC_AS);
    pop[1]   = grant_valid && (grant_src == SRC_MD);
    sel_head = (grant_src == SRC_MD) ? head[1] : head[0];
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      for (int unsigned u = 0; u < 2; u++) begin
        wr_ptr[u] <= '0;
        rd_ptr[u] <= '0;
        count[u]  <= '0;
      end
      cdbValid   <= 1'b0;
      cdbSrc     <= 1'b0;
      cdbTag     <= '0;
      cdbData    <= '0;
      last_grant <= SRC_MD;
    end else begin
      for (int unsigned u = 0; u < 2; u++) begin
        if (push_ok[u]) begin
          mem[u][wr_ptr[u]] <= wr_data[u];
          wr_ptr[u]         <= wr_ptr[u] + 1'b1;
        end
        if (pop[u]) begin
          rd_ptr[u] <= rd_ptr[u] + 1'b1;
        end
        count[u] <= count[u] + CNT_W'(push_ok[u]) - CNT_W'(pop[u]);
      end
      cdbValid <= grant_valid;
      if (grant_valid) begin
        {cdbTag, cdbData} <= sel_head;
        cdbSrc            <= grant_src;
        last_grant        <= grant_src;
      end
    end
  end

  assign fullAS = (count[0] == CNT_W'(DEPTH));
  assign fullMD = (count[1] == CNT_W'(DEPTH));
  assign idle   = (count[0] == '0) && (count[1] == '0) && !cdbValid;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: queue-based reference model fills an
// expected-broadcast queue; a negedge monitor pops and compares.
module tb_cdb_arbiter;

  localparam int TAG_W  = 3;
  localparam int DATA_W = 9;
  localparam int DEPTH  = 2;

  logic              Clock;
  logic              Clear;
  logic              pushAS;
  logic [TAG_W-1:0]  tagAS;
  logic [DATA_W-1:0] dataAS;
  logic              fullAS;
  logic              pushMD;
  logic [TAG_W-1:0]  tagMD;
  logic [DATA_W-1:0] dataMD;
  logic              fullMD;
  logic              cdbHold;
  logic              cdbValid;
  logic              cdbSrc;
  logic [TAG_W-1:0]  cdbTag;
  logic [DATA_W-1:0] cdbData;
  logic              idle;

  cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .Clock(Clock), .Clear(Clear),
    .pushAS(pushAS), .tagAS(tagAS), .dataAS(dataAS), .fullAS(fullAS),
    .pushMD(pushMD), .tagMD(tagMD), .dataMD(dataMD), .fullMD(fullMD),
    .cdbHold(cdbHold), .cdbValid(cdbValid), .cdbSrc(cdbSrc),
    .cdbTag(cdbTag), .cdbData(cdbData), .idle(idle)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic              src;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } bc_t;

  bc_t q_as[$];
  bc_t q_md[$];
  bc_t exp_q[$];
  bc_t m_held;
  bit  m_last;
  bit  exp_valid;
  bit  exp_full_as;
  bit  exp_full_md;
  bit  exp_idle;
  bit  mon_en = 1'b0;
  int  n_checks = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one call per rising edge, using the inputs held across it.
  task automatic model_edge();
    bit  acc_as, acc_md, g;
    int  src;
    bc_t b;
    g = 1'b0;
    src = 0;
    if (Clear) begin
      q_as.delete();
      q_md.delete();
      exp_q.delete();
      m_last = 1'b1;
      m_held = '0;
    end else begin
      acc_as = pushAS && (q_as.size() < DEPTH);
      acc_md = pushMD && (q_md.size() < DEPTH);
      if (!cdbHold) begin
        if (q_as.size() > 0 && q_md.size() > 0) begin g = 1'b1; src = m_last ? 0 : 1; end
        else if (q_as.size() > 0)               begin g = 1'b1; src = 0; end
        else if (q_md.size() > 0)               begin g = 1'b1; src = 1; end
      end
      if (g) begin
        b = (src == 1) ? q_md.pop_front() : q_as.pop_front();
        m_last = (src == 1);
        m_held = b;
        exp_q.push_back(b);
      end
      if (acc_as) q_as.push_back({1'b0, tagAS, dataAS});
      if (acc_md) q_md.push_back({1'b1, tagMD, dataMD});
    end
    exp_valid   = g;
    exp_full_as = (q_as.size() == DEPTH);
    exp_full_md = (q_md.size() == DEPTH);
    exp_idle    = (q_as.size() == 0) && (q_md.size() == 0) && !g;
  endtask

  task automatic step(input bit clr, input bit pa, input logic [TAG_W-1:0] ta,
                      input logic [DATA_W-1:0] da, input bit pm,
                      input logic [TAG_W-1:0] tm, input logic [DATA_W-1:0] dm,
                      input bit hold);
    Clear = clr; pushAS = pa; tagAS = ta; dataAS = da;
    pushMD = pm; tagMD = tm; dataMD = dm; cdbHold = hold;
    @(posedge Clock);
    model_edge();
    #1;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, '0, 0);
  endtask

  always @(negedge Clock) begin
    bc_t b;
    if (mon_en) begin
      chk("cdbValid", 32'(cdbValid), 32'(exp_valid));
      if (cdbValid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_broadcast", 32'({cdbSrc, cdbTag, cdbData}), 32'hFFFF_FFFF);
        end else begin
          b = exp_q.pop_front();
          chk("broadcast", 32'({cdbSrc, cdbTag, cdbData}), 32'(b));
        end
      end else begin
        chk("held_bus", 32'({cdbSrc, cdbTag, cdbData}), 32'(m_held));
      end
      chk("fullAS", 32'(fullAS), 32'(exp_full_as));
      chk("fullMD", 32'(fullMD), 32'(exp_full_md));
      chk("idle", 32'(idle), 32'(exp_idle));
    end
  end

  initial begin
    m_last = 1'b1;
    m_held = '0;
    // Reset with pushes asserted: Clear must win.
    step(1, 1, 3'd7, 9'h1FF, 1, 3'd6, 9'h1AA, 0);
    mon_en = 1'b1;
    step(1, 1, 3'd7, 9'h1FF, 1, 3'd6, 9'h1AA, 0);
    chk("rst_valid", 32'(cdbValid), 32'd0);
    chk("rst_bus", 32'({cdbSrc, cdbTag, cdbData}), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_full", 32'({fullAS, fullMD}), 32'd0);
    idle_steps(2);

    // Single result through an empty system.
    step(0, 1, 3'd3, 9'h055, 0, '0, '0, 0);
    idle_steps(4);
    chk("single_idle", 32'(idle), 32'd1);

    // Tie after reset: AS first, then MD; repeated.
    step(1, 0, '0, '0, 0, '0, '0, 0);
    step(0, 1, 3'd1, 9'h011, 1, 3'd5, 9'h155, 0);
    idle_steps(3);
    step(0, 1, 3'd1, 9'h012, 1, 3'd5, 9'h156, 0);
    idle_steps(3);

    // Full: third push while full is dropped.
    step(0, 1, 3'd1, 9'h101, 0, '0, '0, 1);
    step(0, 1, 3'd2, 9'h102, 0, '0, '0, 1);
    chk("full_after_2", 32'(fullAS), 32'd1);
    step(0, 1, 3'd3, 9'h103, 0, '0, '0, 1);
    idle_steps(4);

    // Hold stalls a queued MD result.
    step(0, 0, '0, '0, 1, 3'd4, 9'h044, 1);
    step(0, 0, '0, '0, 0, '0, '0, 1);
    step(0, 0, '0, '0, 0, '0, '0, 1);
    idle_steps(3);

    // Clear with both FIFOs full.
    step(0, 1, 3'd2, 9'h0A2, 1, 3'd6, 9'h0B6, 1);
    step(0, 1, 3'd3, 9'h0A3, 1, 3'd7, 9'h0B7, 1);
    step(1, 0, '0, '0, 0, '0, '0, 0);
    chk("clr_full", 32'({fullAS, fullMD}), 32'd0);
    chk("clr_idle", 32'(idle), 32'd1);
    idle_steps(4);

    // Randomised traffic with occasional hold and clear.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 55, 3'($urandom), 9'($urandom),
           $urandom_range(0, 99) < 55, 3'($urandom), 9'($urandom),
           $urandom_range(0, 99) < 20);
    end
    idle_steps(8);
    chk("drained", 32'(exp_q.size()), 32'd0);
    chk("final_idle", 32'(idle), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
